// File: rtl/globals_afu_pkg.sv
// rtl/globals_afu_pkg.sv - shared AFU enums, statistics register map and cacheline size
package globals_afu_pkg;

  localparam int CACHELINE_SIZE = 128;

  typedef enum logic [7:0] {
    RESP_DONE    = 8'h00,
    RESP_AERROR  = 8'h01,
    RESP_DERROR  = 8'h03,
    RESP_NLOCK   = 8'h04,
    RESP_NRES    = 8'h05,
    RESP_FLUSHED = 8'h06,
    RESP_FAULT   = 8'h07,
    RESP_FAILED  = 8'h08,
    RESP_PAGED   = 8'h0A
  } psl_response_t;

  typedef enum logic [2:0] {
    CLASS_NONE           = 3'd0,
    CLASS_READ           = 3'd1,
    CLASS_WRITE          = 3'd2,
    CLASS_PREFETCH_READ  = 3'd3,
    CLASS_PREFETCH_WRITE = 3'd4,
    CLASS_RESTART        = 3'd5
  } cmd_class_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ACK    = 2'd2
  } mmio_state_t;

  typedef enum logic [4:0] {
    S_DONE, S_DONE_RESTART, S_DONE_READ, S_DONE_WRITE, S_DONE_PREFETCH_READ,
    S_DONE_PREFETCH_WRITE, S_PAGED, S_FLUSHED, S_AERROR, S_DERROR, S_FAILED,
    S_FAULT, S_NRES, S_NLOCK, S_CYCLE, S_READ_BYTE, S_WRITE_BYTE, S_PREFETCH_READ_BYTE
  } stat_t;

  localparam int NUM_STATS = 18;

  // 64-bit registers occupy two 32-bit words, hence the stride of 2
  localparam logic [23:0] CYCLE_COUNT_REG               = 24'hFFFFEA;
  localparam logic [23:0] DONE_COUNT_REG                = 24'hFFFFE6;
  localparam logic [23:0] DONE_READ_COUNT_REG           = 24'hFFFFE4;
  localparam logic [23:0] DONE_WRITE_COUNT_REG          = 24'hFFFFE2;
  localparam logic [23:0] DONE_RESTART_COUNT_REG        = 24'hFFFFE0;
  localparam logic [23:0] PAGED_COUNT_REG               = 24'hFFFFDE;
  localparam logic [23:0] FLUSHED_COUNT_REG             = 24'hFFFFDC;
  localparam logic [23:0] AERROR_COUNT_REG              = 24'hFFFFDA;
  localparam logic [23:0] DERROR_COUNT_REG              = 24'hFFFFD8;
  localparam logic [23:0] FAILED_COUNT_REG              = 24'hFFFFD6;
  localparam logic [23:0] FAULT_COUNT_REG               = 24'hFFFFD4;
  localparam logic [23:0] NRES_COUNT_REG                = 24'hFFFFD2;
  localparam logic [23:0] NLOCK_COUNT_REG               = 24'hFFFFD0;
  localparam logic [23:0] DONE_PREFETCH_READ_COUNT_REG  = 24'hFFFFCE;
  localparam logic [23:0] DONE_PREFETCH_WRITE_COUNT_REG = 24'hFFFFCC;
  localparam logic [23:0] PREFETCH_READ_BYTE_COUNT_REG  = 24'hFFFFCA;
  localparam logic [23:0] READ_BYTE_COUNT_REG           = 24'hFFFFC8;
  localparam logic [23:0] WRITE_BYTE_COUNT_REG          = 24'hFFFFC6;

  typedef struct packed {
    logic  hit;
    stat_t idx;
  } reg_hit_t;

  function automatic reg_hit_t reg_lookup(input logic [23:0] addr);
    reg_hit_t r;
    r.hit = 1'b1;
    r.idx = S_DONE;
    case (addr)
      CYCLE_COUNT_REG:               r.idx = S_CYCLE;
      DONE_COUNT_REG:                r.idx = S_DONE;
      DONE_READ_COUNT_REG:           r.idx = S_DONE_READ;
      DONE_WRITE_COUNT_REG:          r.idx = S_DONE_WRITE;
      DONE_RESTART_COUNT_REG:        r.idx = S_DONE_RESTART;
      PAGED_COUNT_REG:               r.idx = S_PAGED;
      FLUSHED_COUNT_REG:             r.idx = S_FLUSHED;
      AERROR_COUNT_REG:              r.idx = S_AERROR;
      DERROR_COUNT_REG:              r.idx = S_DERROR;
      FAILED_COUNT_REG:              r.idx = S_FAILED;
      FAULT_COUNT_REG:               r.idx = S_FAULT;
      NRES_COUNT_REG:                r.idx = S_NRES;
      NLOCK_COUNT_REG:               r.idx = S_NLOCK;
      DONE_PREFETCH_READ_COUNT_REG:  r.idx = S_DONE_PREFETCH_READ;
      DONE_PREFETCH_WRITE_COUNT_REG: r.idx = S_DONE_PREFETCH_WRITE;
      PREFETCH_READ_BYTE_COUNT_REG:  r.idx = S_PREFETCH_READ_BYTE;
      READ_BYTE_COUNT_REG:           r.idx = S_READ_BYTE;
      WRITE_BYTE_COUNT_REG:          r.idx = S_WRITE_BYTE;
      default:                       r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stat_counter_sat.sv
// rtl/stat_counter_sat.sv - saturating statistics counter with clear, enable and increment amount
module stat_counter_sat #(
  parameter int WIDTH     = 64,
  parameter int INC_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 rstn,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [INC_WIDTH-1:0] amount,
  output logic [WIDTH-1:0]     count
);

  // One spare bit above the wider operand catches any overflow
  localparam int SUM_W = ((WIDTH > INC_WIDTH) ? WIDTH : INC_WIDTH) + 1;
  localparam logic [SUM_W-1:0] LIMIT = SUM_W'({WIDTH{1'b1}});

  logic [SUM_W-1:0] sum;
  assign sum = SUM_W'(count) + SUM_W'(amount);

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (sum > LIMIT) ? '1 : sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mmio_stats_responder.sv
// rtl/mmio_stats_responder.sv - PSL response statistics with MMIO readback; CYCLE counter under CYCLE_COUNT_EN
module mmio_stats_responder
  import globals_afu_pkg::*;
#(
  parameter int COUNTER_WIDTH = 64
) (
  input  logic        clock,
  input  logic        rstn,
  input  logic        enabled_in,
  input  logic        stats_clear_in,
  input  logic        response_valid_in,
  input  logic [7:0]  response_code_in,
  input  logic [2:0]  response_class_in,
  input  logic        mmio_valid_in,
  input  logic        mmio_read_in,
  input  logic        mmio_dw_in,
  input  logic [0:23] mmio_address_in,
  output logic        mmio_ack_out,
  output logic [0:63] mmio_data_out,
  output logic        mmio_data_par_out
);

  logic [NUM_STATS-1:0]     inc;
  logic [COUNTER_WIDTH-1:0] cnt [NUM_STATS];

  always_comb begin
    inc = '0;
    inc[S_CYCLE] = enabled_in;
    if (response_valid_in && enabled_in) begin
      case (response_code_in)
        RESP_DONE: begin
          inc[S_DONE] = 1'b1;
          case (response_class_in)
            CLASS_READ:           begin inc[S_DONE_READ] = 1'b1; inc[S_READ_BYTE] = 1'b1; end
            CLASS_WRITE:          begin inc[S_DONE_WRITE] = 1'b1; inc[S_WRITE_BYTE] = 1'b1; end
            CLASS_PREFETCH_READ:  begin inc[S_DONE_PREFETCH_READ] = 1'b1; inc[S_PREFETCH_READ_BYTE] = 1'b1; end
            CLASS_PREFETCH_WRITE: inc[S_DONE_PREFETCH_WRITE] = 1'b1;
            CLASS_RESTART:        inc[S_DONE_RESTART] = 1'b1;
            default: ;
          endcase
        end
        RESP_AERROR:  inc[S_AERROR]  = 1'b1;
        RESP_DERROR:  inc[S_DERROR]  = 1'b1;
        RESP_NLOCK:   inc[S_NLOCK]   = 1'b1;
        RESP_NRES:    inc[S_NRES]    = 1'b1;
        RESP_FLUSHED: inc[S_FLUSHED] = 1'b1;
        RESP_FAULT:   inc[S_FAULT]   = 1'b1;
        RESP_FAILED:  inc[S_FAILED]  = 1'b1;
        RESP_PAGED:   inc[S_PAGED]   = 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_STATS; i++) begin : g_stat
    localparam logic [7:0] AMT = (i == int'(S_READ_BYTE) || i == int'(S_WRITE_BYTE) ||
                                  i == int'(S_PREFETCH_READ_BYTE)) ? 8'(CACHELINE_SIZE) : 8'd1;
    if (i == int'(S_CYCLE)) begin : g_cycle
`ifdef CYCLE_COUNT_EN
      stat_counter_sat #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(8)) u_cnt (
        .clock(clock), .rstn(rstn), .clear(stats_clear_in),
        .enable(inc[i]), .amount(AMT), .count(cnt[i]));
`else
      assign cnt[i] = '0;
`endif
    end else begin : g_resp
      stat_counter_sat #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(8)) u_cnt (
        .clock(clock), .rstn(rstn), .clear(stats_clear_in),
        .enable(inc[i]), .amount(AMT), .count(cnt[i]));
    end
  end

  mmio_state_t state;
  logic [23:0] addr_q;
  logic        read_q;
  logic        dw_q;
  reg_hit_t    hit;
  logic [63:0] value;
  logic [63:0] rdata;

  always_comb begin
    hit = reg_lookup(addr_q);
    value = '0;
    value[COUNTER_WIDTH-1:0] = cnt[hit.idx];
    if (!read_q)   rdata = '0;
    else if (dw_q) rdata = value;
    else           rdata = {value[31:0], value[31:0]};
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state             <= ST_IDLE;
      addr_q            <= '0;
      read_q            <= 1'b0;
      dw_q              <= 1'b0;
      mmio_ack_out      <= 1'b0;
      mmio_data_out     <= '0;
      mmio_data_par_out <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mmio_valid_in) begin
            addr_q <= mmio_address_in;
            read_q <= mmio_read_in;
            dw_q   <= mmio_dw_in;
            state  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          // Unmapped addresses belong to another responder: stay silent
          if (hit.hit) begin
            mmio_ack_out      <= 1'b1;
            mmio_data_out     <= rdata;
            mmio_data_par_out <= ~^rdata;
            state             <= ST_ACK;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACK: begin
          mmio_ack_out      <= 1'b0;
          mmio_data_out     <= '0;
          mmio_data_par_out <= 1'b1;
          state             <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_stats_responder.sv
// tb/tb_mmio_stats_responder.sv - scoreboard bench driving a 64-bit and a 4-bit counter instance in lockstep
module tb_mmio_stats_responder;

  logic        clock = 1'b0;
  logic        rstn;
  logic        enabled_in, stats_clear_in, response_valid_in;
  logic [7:0]  response_code_in;
  logic [2:0]  response_class_in;
  logic        mmio_valid_in, mmio_read_in, mmio_dw_in;
  logic [23:0] mmio_address_in;
  logic        ack_o  [2];
  logic [63:0] data_o [2];
  logic        par_o  [2];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [63:0] expq  [2][$];
  string       nameq [2][$];
  logic [63:0] mon_e;
  string       mon_n;

  always #5 clock = ~clock;

  mmio_stats_responder u_w64 (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .stats_clear_in(stats_clear_in),
    .response_valid_in(response_valid_in), .response_code_in(response_code_in),
    .response_class_in(response_class_in), .mmio_valid_in(mmio_valid_in),
    .mmio_read_in(mmio_read_in), .mmio_dw_in(mmio_dw_in), .mmio_address_in(mmio_address_in),
    .mmio_ack_out(ack_o[0]), .mmio_data_out(data_o[0]), .mmio_data_par_out(par_o[0]));

  mmio_stats_responder #(.COUNTER_WIDTH(4)) u_w4 (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .stats_clear_in(stats_clear_in),
    .response_valid_in(response_valid_in), .response_code_in(response_code_in),
    .response_class_in(response_class_in), .mmio_valid_in(mmio_valid_in),
    .mmio_read_in(mmio_read_in), .mmio_dw_in(mmio_dw_in), .mmio_address_in(mmio_address_in),
    .mmio_ack_out(ack_o[1]), .mmio_data_out(data_o[1]), .mmio_data_par_out(par_o[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      for (int j = 0; j < 2; j++) begin
        if (ack_o[j]) begin
          if (expq[j].size() == 0) begin
            check($sformatf("unexpected_ack_d%0d", j), 64'd1, 64'd0);
          end else begin
            mon_e = expq[j].pop_front();
            mon_n = nameq[j].pop_front();
            check($sformatf("%s_d%0d_data", mon_n, j), data_o[j], mon_e);
            check($sformatf("%s_d%0d_par", mon_n, j), {63'd0, par_o[j]}, {63'd0, ~^mon_e});
          end
        end else begin
          check($sformatf("idle_d%0d_data", j), data_o[j], 64'd0);
          check($sformatf("idle_d%0d_par", j), {63'd0, par_o[j]}, 64'd1);
        end
      end
    end
  end

  task automatic send_resp(input logic [7:0] code, input logic [2:0] cls, input int n, input logic clr);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      response_valid_in = 1'b1;
      response_code_in  = code;
      response_class_in = cls;
      stats_clear_in    = clr;
    end
    @(posedge clock); #1;
    response_valid_in = 1'b0;
    stats_clear_in    = 1'b0;
  endtask

  task automatic mmio(input string name, input logic rd, input logic dw, input logic [23:0] addr,
                      input logic ack_exp, input logic [63:0] e64, input logic [63:0] e4);
    int lat [2];
    if (ack_exp) begin
      expq[0].push_back(e64); nameq[0].push_back(name);
      expq[1].push_back(e4);  nameq[1].push_back(name);
    end
    @(posedge clock); #1;
    mmio_valid_in = 1'b1; mmio_read_in = rd; mmio_dw_in = dw; mmio_address_in = addr;
    lat[0] = -1; lat[1] = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      for (int j = 0; j < 2; j++) if (ack_o[j] && lat[j] < 0) lat[j] = k;
      if (k == 0) begin
        @(posedge clock); #1;
        mmio_valid_in = 1'b0;
      end
    end
    for (int j = 0; j < 2; j++)
      check($sformatf("%s_d%0d_latency", name, j), 64'(lat[j]), ack_exp ? 64'd2 : 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b1; enabled_in = 1'b1; stats_clear_in = 1'b0; response_valid_in = 1'b0;
    response_code_in = 8'h00; response_class_in = 3'd0;
    mmio_valid_in = 1'b0; mmio_read_in = 1'b0; mmio_dw_in = 1'b0; mmio_address_in = 24'h0;
    #2 rstn = 1'b0;
    #1 mon_en = 1'b1;
    @(negedge clock);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("rst_ack_d%0d", j), {63'd0, ack_o[j]}, 64'd0);
      check($sformatf("rst_data_d%0d", j), data_o[j], 64'd0);
      check($sformatf("rst_par_d%0d", j), {63'd0, par_o[j]}, 64'd1);
    end
    @(posedge clock); #1 rstn = 1'b1;
    repeat (2) @(posedge clock);

    send_resp(8'h00, 3'd1, 5, 1'b0);
    mmio("done",        1, 1, 24'hFFFFE6, 1, 64'd5, 64'd5);
    mmio("done_read",   1, 1, 24'hFFFFE4, 1, 64'd5, 64'd5);
    mmio("read_byte32", 1, 0, 24'hFFFFC8, 1, 64'h0000028000000280, 64'h0000000F0000000F);

    send_resp(8'h00, 3'd2, 3, 1'b0);
    mmio("write_byte32", 1, 0, 24'hFFFFC6, 1, 64'h0000018000000180, 64'h0000000F0000000F);
    mmio("done_write",   1, 1, 24'hFFFFE2, 1, 64'd3, 64'd3);
    mmio("done_total",   1, 1, 24'hFFFFE6, 1, 64'd8, 64'd8);

    send_resp(8'h0A, 3'd0, 20, 1'b0);
    mmio("paged_sat", 1, 1, 24'hFFFFDE, 1, 64'd20, 64'd15);

    send_resp(8'h08, 3'd0, 1, 1'b0);
    send_resp(8'h08, 3'd0, 1, 1'b1);
    mmio("failed_clr", 1, 1, 24'hFFFFD6, 1, 64'd0, 64'd0);
    mmio("done_clr",   1, 1, 24'hFFFFE6, 1, 64'd0, 64'd0);
    mmio("paged_clr",  1, 1, 24'hFFFFDE, 1, 64'd0, 64'd0);

    enabled_in = 1'b0;
    send_resp(8'h06, 3'd0, 2, 1'b0);
    mmio("flushed_hold", 1, 1, 24'hFFFFDC, 1, 64'd0, 64'd0);
    enabled_in = 1'b1;
    send_resp(8'h06, 3'd0, 1, 1'b0);
    mmio("flushed_one", 1, 1, 24'hFFFFDC, 1, 64'd1, 64'd1);

    mmio("unmapped", 1, 1, 24'h000010, 0, 64'd0, 64'd0);
    mmio("cycle_off", 1, 1, 24'hFFFFEA, 1, 64'd0, 64'd0);

    send_resp(8'h00, 3'd5, 1, 1'b0);
    mmio("done_restart", 1, 1, 24'hFFFFE0, 1, 64'd1, 64'd1);
    mmio("rbyte_zero",   1, 1, 24'hFFFFC8, 1, 64'd0, 64'd0);
    send_resp(8'h02, 3'd0, 2, 1'b0);
    send_resp(8'h05, 3'd0, 1, 1'b0);
    mmio("nres",   1, 1, 24'hFFFFD2, 1, 64'd1, 64'd1);
    mmio("aerror", 1, 1, 24'hFFFFDA, 1, 64'd0, 64'd0);
    mmio("derror", 1, 1, 24'hFFFFD8, 1, 64'd0, 64'd0);
    send_resp(8'h00, 3'd3, 1, 1'b0);
    send_resp(8'h00, 3'd4, 1, 1'b0);
    mmio("pf_rd_byte", 1, 1, 24'hFFFFCA, 1, 64'd128, 64'd15);
    mmio("done_pf_rd", 1, 1, 24'hFFFFCE, 1, 64'd1, 64'd1);
    mmio("done_pf_wr", 1, 1, 24'hFFFFCC, 1, 64'd1, 64'd1);
    mmio("write_ack",  0, 1, 24'hFFFFE6, 1, 64'd0, 64'd0);

    begin
      logic seen;
      seen = 1'b0;
      @(posedge clock); #1;
      mmio_valid_in = 1'b1; mmio_read_in = 1'b1; mmio_dw_in = 1'b1; mmio_address_in = 24'hFFFFE6;
      @(posedge clock); #1;
      mmio_valid_in = 1'b0;
      rstn = 1'b0;
      repeat (2) @(posedge clock);
      #1 rstn = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clock);
        if (ack_o[0] || ack_o[1]) seen = 1'b1;
      end
      check("rst_in_decode_no_ack", {63'd0, seen}, 64'd0);
    end
    mmio("post_rst_done",  1, 1, 24'hFFFFE6, 1, 64'd0, 64'd0);
    mmio("post_rst_nres",  1, 1, 24'hFFFFD2, 1, 64'd0, 64'd0);
    mmio("post_rst_pfrd",  1, 0, 24'hFFFFCA, 1, 64'd0, 64'd0);

    repeat (3) @(posedge clock);
    check("drain_d0", 64'(expq[0].size()), 64'd0);
    check("drain_d1", 64'(expq[1].size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_stats_responder.md
MMIO_STATS_RESPONDER -- requirements
Module: mmio_stats_responder

Interface
- REQ-001 SHALL have parameter COUNTER_WIDTH, default 64: width of each statistics counter, 1..64; read data zero-extended to 64 bits.
- REQ-002 SHALL have port clock, input, 1 bit: single clock for all logic.
- REQ-003 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
- REQ-004 SHALL have port enabled_in, input, 1 bit: counting enable.
- REQ-005 SHALL have port stats_clear_in, input, 1 bit: synchronous clear of all counters.
- REQ-006 SHALL have port response_valid_in, input, 1 bit: PSL response strobe.
- REQ-007 SHALL have port response_code_in, input, 8 bits: PSL response code, one of DONE 0x00, AERROR 0x01, DERROR 0x03, NLOCK 0x04, NRES 0x05, FLUSHED 0x06, FAULT 0x07, FAILED 0x08, PAGED 0x0A.
- REQ-008 SHALL have port response_class_in, input, 3 bits: command class of the response, one of NONE 0, READ 1, WRITE 2, PREFETCH_READ 3, PREFETCH_WRITE 4, RESTART 5.
- REQ-009 SHALL have port mmio_valid_in, input, 1 bit: host MMIO request strobe.
- REQ-010 SHALL have port mmio_read_in, input, 1 bit: 1 = read, 0 = write.
- REQ-011 SHALL have port mmio_dw_in, input, 1 bit: 1 = 64-bit access, 0 = 32-bit access.
- REQ-012 SHALL have port mmio_address_in, input, 24 bits, [0:23]: word address.
- REQ-013 SHALL have port mmio_ack_out, output, 1 bit: one-cycle acknowledge.
- REQ-014 SHALL have port mmio_data_out, output, 64 bits, [0:63]: read data.
- REQ-015 SHALL have port mmio_data_par_out, output, 1 bit: odd parity over mmio_data_out.

Function
- REQ-016 SHALL keep 18 counters: DONE, DONE_RESTART, DONE_READ, DONE_WRITE, DONE_PREFETCH_READ, DONE_PREFETCH_WRITE, PAGED, FLUSHED, AERROR, DERROR, FAILED, FAULT, NRES, NLOCK, CYCLE, and byte counters READ_BYTE, WRITE_BYTE, PREFETCH_READ_BYTE.
- REQ-017 SHALL, when response_valid_in=1 and enabled_in=1, increment the counter matching response_code_in by 1; for DONE it SHALL also increment the matching DONE_<class> counter by 1 and the matching <class>_BYTE counter by 128 (CACHELINE_SIZE); class NONE gets no class or byte increment; a RESTART DONE increments DONE_RESTART only.
- REQ-018 SHALL ignore unlisted response codes.
- REQ-019 SHALL saturate every counter at all-ones; no wrap-around.
- REQ-020 SHALL give stats_clear_in priority over any same-cycle increment: affected counters read 0 on the next cycle and the coincident response is dropped.
- REQ-021 SHALL hold all counters while enabled_in=0; MMIO service continues.
- REQ-022 SHALL use states IDLE -> DECODE -> ACK -> IDLE. IDLE captures the request on mmio_valid_in. DECODE matches the address against the package register constants. ACK pulses mmio_ack_out for exactly 1 cycle.
- REQ-023 SHALL ack with 2-cycle latency: valid at cycle N gives ack at N+2.
- REQ-024 SHALL return, on a 64-bit read, the counter zero-extended, with the MSB at bit 0.
- REQ-025 SHALL return, on a 32-bit read, the low 32 bits replicated in both halves.
- REQ-026 SHALL present data with the ack cycle, and drive data to 0 on all other cycles.
- REQ-027 SHALL ack writes to mapped addresses with data 0; written data is discarded.
- REQ-028 SHALL NOT ack unmapped addresses and SHALL return to IDLE; other responders own them.
- REQ-029 SHALL ignore mmio_valid_in outside IDLE, since the host keeps only one MMIO outstanding.
- REQ-030 SHALL sample the counter value for a read in DECODE; increments in the same cycle are not visible.

Reset
- REQ-031 SHALL, while rstn=0, immediately force all counters to 0, the FSM to IDLE, mmio_ack_out=0, mmio_data_out=0 and mmio_data_par_out=1.
- REQ-032 SHALL abandon any in-flight MMIO on reset assertion, without an ack.

Configuration
- REQ-033 SHALL compile the CYCLE counter under the macro CYCLE_COUNT_EN. When defined, CYCLE increments every clock while enabled_in=1, under the same saturation and clear rules. When undefined, no CYCLE register exists and CYCLE_COUNT_REG reads ack with data 0.

Structure
- REQ-034 SHALL take the register word addresses (DONE_COUNT_REG ... WRITE_BYTE_COUNT_REG) and CACHELINE_SIZE from GLOBALS_AFU_PKG.
- REQ-035 SHALL place the response-code enum, the command-class enum and the MMIO FSM state enum in the shared AFU package.
- REQ-036 SHALL implement each counter as one sub-module, stat_counter_sat, a saturating counter with clear, enable and increment amount.

Verification
- REQ-037 SHALL cover: 5 DONE/READ responses, then a 64-bit read at 0xFFFFE6 -> ack at N+2, data 5, parity 1.
- REQ-038 SHALL cover: 3 DONE/WRITE responses, then a 32-bit read of WRITE_BYTE at 0xFFFFC6 -> data 0x0000018000000180.
- REQ-039 SHALL cover: COUNTER_WIDTH=4 with 20 PAGED responses -> a read at 0xFFFFDE returns 15.
- REQ-040 SHALL cover: stats_clear_in coincident with a FAILED response -> a read at 0xFFFFD6 returns 0.
- REQ-041 SHALL cover: a read at unmapped 0x000010 -> no ack for 10 cycles; a following read at 0xFFFFEA acks normally.
- REQ-042 SHALL cover: rstn pulsed low during DECODE -> no ack, and all counters read 0 after reset.
